// File: rtl/output_readback_manager_pkg.sv
// Shared definitions for the output read-back sequencer: FSM encoding,
// header field layout, instruction codes and parameter defaults.
package output_readback_manager_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_SEND = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    localparam logic [15:0] MAGIC_DEFAULT     = 16'hC0DE;
    localparam logic [7:0]  INSTR_READ_CODE   = 8'h02;
    localparam logic [15:0] MAX_CHUNK_DEFAULT = 16'd256;
    localparam logic [19:0] TIMEOUT_DEFAULT   = 20'hFFFFF;

    localparam int W2_BRAM_START_LSB = 13;
    localparam int W2_BRAM_END_LSB   = 10;
    localparam int W2_NOTIFY_BIT     = 9;
    localparam int W5_SEQ_LSB        = 8;

    function automatic logic [15:0] pack_w2(input logic [2:0] bram_start,
                                            input logic [2:0] bram_end,
                                            input logic       notify);
        logic [15:0] w;
        w = '0;
        w[W2_BRAM_START_LSB +: 3] = bram_start;
        w[W2_BRAM_END_LSB +: 3]   = bram_end;
        w[W2_NOTIFY_BIT]          = notify;
        return w;
    endfunction

    function automatic logic [15:0] pack_w5(input logic [7:0] seq,
                                            input logic [7:0] remaining_lo);
        logic [15:0] w;
        w = '0;
        w[W5_SEQ_LSB +: 8] = seq;
        w[7:0]             = remaining_lo;
        return w;
    endfunction

endpackage

// File: rtl/output_readback_manager_timeout.sv
// Watchdog for the read_done handshake: cleared on load, counts while enabled,
// flags expiry after TIMEOUT enabled cycles.
module output_readback_manager_timeout
    import output_readback_manager_pkg::*;
#(
    parameter logic [19:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic aclk,
    input  logic areset,
    input  logic load,
    input  logic enable,
    output logic expire
);
    logic [19:0] count;

    assign expire = enable && (count == TIMEOUT - 20'd1);

    always_ff @(posedge aclk) begin
        if (areset || load) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + 20'd1;
        end
    end

endmodule

// File: rtl/output_readback_manager.sv
// Splits a layer's output region into chunks and hands one read header per
// chunk to the stream wrapper, advancing on read_done or giving up on timeout.
module output_readback_manager
    import output_readback_manager_pkg::*;
#(
    parameter logic [15:0] MAGIC      = MAGIC_DEFAULT,
    parameter logic [7:0]  INSTR_READ = INSTR_READ_CODE,
    parameter logic [15:0] MAX_CHUNK  = MAX_CHUNK_DEFAULT,
    parameter logic [19:0] TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        start,
    input  logic        notify_mode,
    input  logic [7:0]  layer_id,
    input  logic [2:0]  cfg_bram_start,
    input  logic [2:0]  cfg_bram_end,
    input  logic [15:0] cfg_addr_count,
    input  logic        read_done,
    output logic [15:0] header_word_0,
    output logic [15:0] header_word_1,
    output logic [15:0] header_word_2,
    output logic [15:0] header_word_3,
    output logic [15:0] header_word_4,
    output logic [15:0] header_word_5,
    output logic        send_header,
    output logic        notification_only,
    output logic [2:0]  out_mgr_rd_bram_start,
    output logic [2:0]  out_mgr_rd_bram_end,
    output logic [15:0] out_mgr_rd_addr_count,
    output logic        busy,
    output logic        layer_done,
    output logic        error_timeout
);
    logic [2:0]  state;
    logic [15:0] remaining;
    logic [15:0] addr_base;
    logic [15:0] chunk;
    logic [7:0]  seq;
    logic [7:0]  layer_id_r;
    logic [2:0]  bram_start_r;
    logic [2:0]  bram_end_r;
    logic        notify_r;
    logic [15:0] next_chunk;
    logic [7:0]  remaining_after_lo;
    logic        timer_expire;

    // NOTE: defaults assigned first so no path leaves a comb output unassigned (no latch).
    always_comb begin
        next_chunk = '0;
        if (!notify_r) begin
            next_chunk = (remaining > MAX_CHUNK) ? MAX_CHUNK : remaining;
        end
        remaining_after_lo = remaining[7:0] - next_chunk[7:0];
    end

    assign busy       = (state != ST_IDLE) && (state != ST_FIN);
    assign layer_done = (state == ST_FIN);

    output_readback_manager_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .aclk   (aclk),
        .areset (areset),
        .load   (state == ST_SEND),
        .enable (state == ST_WAIT),
        .expire (timer_expire)
    );

    // NOTE: state uses <= so every register updates from pre-edge values.
    always_ff @(posedge aclk) begin
        // NOTE: everything here is plain flops, header words included, so all take reset.
        if (areset) begin
            state                 <= ST_IDLE;
            remaining             <= '0;
            addr_base             <= '0;
            chunk                 <= '0;
            seq                   <= '0;
            layer_id_r            <= '0;
            bram_start_r          <= '0;
            bram_end_r            <= '0;
            notify_r              <= 1'b0;
            header_word_0         <= '0;
            header_word_1         <= '0;
            header_word_2         <= '0;
            header_word_3         <= '0;
            header_word_4         <= '0;
            header_word_5         <= '0;
            send_header           <= 1'b0;
            notification_only     <= 1'b0;
            out_mgr_rd_bram_start <= '0;
            out_mgr_rd_bram_end   <= '0;
            out_mgr_rd_addr_count <= '0;
            error_timeout         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        layer_id_r    <= layer_id;
                        bram_start_r  <= cfg_bram_start;
                        bram_end_r    <= cfg_bram_end;
                        notify_r      <= notify_mode;
                        remaining     <= cfg_addr_count;
                        addr_base     <= '0;
                        seq           <= '0;
                        error_timeout <= 1'b0;
                        state         <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (remaining == '0 && !notify_r) begin
                        state <= ST_FIN;
                    end else begin
                        chunk                 <= next_chunk;
                        header_word_0         <= MAGIC;
                        header_word_1         <= {INSTR_READ, layer_id_r};
                        header_word_2         <= pack_w2(bram_start_r, bram_end_r, notify_r);
                        header_word_3         <= addr_base;
                        header_word_4         <= next_chunk;
                        header_word_5         <= pack_w5(seq, remaining_after_lo);
                        out_mgr_rd_bram_start <= bram_start_r;
                        out_mgr_rd_bram_end   <= bram_end_r;
                        out_mgr_rd_addr_count <= next_chunk;
                        state                 <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    send_header       <= 1'b1;
                    notification_only <= notify_r;
                    state             <= ST_WAIT;
                end
                ST_WAIT: begin
                    // read_done takes priority over a same-cycle timeout.
                    if (read_done) begin
                        send_header       <= 1'b0;
                        notification_only <= 1'b0;
                        remaining         <= remaining - chunk;
                        addr_base         <= addr_base + chunk;
                        seq               <= seq + 8'd1;
                        state             <= (remaining == chunk || notify_r) ? ST_FIN : ST_LOAD;
                    end else if (timer_expire) begin
                        send_header       <= 1'b0;
                        notification_only <= 1'b0;
                        error_timeout     <= 1'b1;
                        state             <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_readback_manager.sv
// Self-checking bench for output_readback_manager: directed table, corner-case
// sequences and randomized layers against a chunking model.
module tb_output_readback_manager;

    logic        aclk = 1'b0;
    logic        areset;
    logic        start;
    logic        notify_mode;
    logic [7:0]  layer_id;
    logic [2:0]  cfg_bram_start;
    logic [2:0]  cfg_bram_end;
    logic [15:0] cfg_addr_count;
    logic        read_done;
    logic [15:0] header_word_0, header_word_1, header_word_2;
    logic [15:0] header_word_3, header_word_4, header_word_5;
    logic        send_header;
    logic        notification_only;
    logic [2:0]  out_mgr_rd_bram_start;
    logic [2:0]  out_mgr_rd_bram_end;
    logic [15:0] out_mgr_rd_addr_count;
    logic        busy;
    logic        layer_done;
    logic        error_timeout;

    int tests = 0;
    int fails = 0;

    output_readback_manager #(
        .TIMEOUT (20'd100)
    ) dut (
        .aclk                  (aclk),
        .areset                (areset),
        .start                 (start),
        .notify_mode           (notify_mode),
        .layer_id              (layer_id),
        .cfg_bram_start        (cfg_bram_start),
        .cfg_bram_end          (cfg_bram_end),
        .cfg_addr_count        (cfg_addr_count),
        .read_done             (read_done),
        .header_word_0         (header_word_0),
        .header_word_1         (header_word_1),
        .header_word_2         (header_word_2),
        .header_word_3         (header_word_3),
        .header_word_4         (header_word_4),
        .header_word_5         (header_word_5),
        .send_header           (send_header),
        .notification_only     (notification_only),
        .out_mgr_rd_bram_start (out_mgr_rd_bram_start),
        .out_mgr_rd_bram_end   (out_mgr_rd_bram_end),
        .out_mgr_rd_addr_count (out_mgr_rd_addr_count),
        .busy                  (busy),
        .layer_done            (layer_done),
        .error_timeout         (error_timeout)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the k-th packet of a layer of `count` words covers
    // words [256k, 256k+chunk) of each BRAM.
    function automatic int model_packets(input int count, input bit notify);
        return notify ? 1 : (count + 255) / 256;
    endfunction

    function automatic int model_chunk(input int count, input bit notify, input int k);
        int left;
        if (notify) return 0;
        left = count - 256 * k;
        return (left > 256) ? 256 : left;
    endfunction

    task automatic check_packet(input int count, input bit notify, input logic [2:0] bs,
                                input logic [2:0] be, input logic [7:0] lid, input int k);
        int base;
        int chunk;
        int after;
        base  = notify ? 0 : 256 * k;
        chunk = model_chunk(count, notify, k);
        after = count - base - chunk;
        check("w0_magic", 32'(header_word_0), 32'h0000_C0DE);
        check("w1_instr_layer", 32'(header_word_1), 32'({8'h02, lid}));
        check("w2_brams_notify", 32'(header_word_2), 32'({bs, be, notify, 9'b0}));
        check("w3_addr_base", 32'(header_word_3), 32'(base[15:0]));
        check("w4_chunk", 32'(header_word_4), 32'(chunk[15:0]));
        check("w5_seq_remaining", 32'(header_word_5), 32'({k[7:0], after[7:0]}));
        check("notification_only", 32'(notification_only), 32'(notify));
        check("rd_bram_start", 32'(out_mgr_rd_bram_start), 32'(bs));
        check("rd_bram_end", 32'(out_mgr_rd_bram_end), 32'(be));
        check("rd_addr_count", 32'(out_mgr_rd_addr_count), 32'(chunk[15:0]));
        check("busy_in_wait", 32'(busy), 32'd1);
    endtask

    // Runs one layer from start to layer_done; called at a negedge.
    task automatic run_layer(input logic [15:0] count, input bit notify, input logic [2:0] bs,
                             input logic [2:0] be, input logic [7:0] lid, input bit intrude,
                             output int pkts, output logic [15:0] last_chunk);
        int  exp_n;
        int  lat;
        bit  seen;
        bit  ever_high;
        pkts       = 0;
        last_chunk = '0;
        exp_n      = model_packets(int'(count), notify);
        cfg_addr_count = count;
        notify_mode    = notify;
        cfg_bram_start = bs;
        cfg_bram_end   = be;
        layer_id       = lid;
        start          = 1'b1;
        for (int k = 0; k < exp_n; k++) begin
            lat  = 0;
            seen = 1'b0;
            while (!seen && lat < 10) begin
                @(negedge aclk);
                start     = 1'b0;
                read_done = 1'b0;
                lat++;
                if (k > 0 && lat == 1) check("send_drop_after_done", 32'(send_header), 32'd0);
                if (send_header) seen = 1'b1;
            end
            check("send_header_latency", 32'(lat), 32'd3);
            if (!seen) return;
            pkts++;
            check_packet(int'(count), notify, bs, be, lid, k);
            last_chunk = header_word_4;
            if (intrude && k == 0) begin
                start          = 1'b1;
                cfg_addr_count = ~count;
                cfg_bram_start = ~bs;
                cfg_bram_end   = ~be;
                layer_id       = ~lid;
                notify_mode    = ~notify;
                @(negedge aclk);
                start = 1'b0;
                check_packet(int'(count), notify, bs, be, lid, k);
            end
            repeat ($urandom_range(0, 4)) begin
                @(negedge aclk);
                check("hold_send_header", 32'(send_header), 32'd1);
                check("hold_w4", 32'(header_word_4), 32'(model_chunk(int'(count), notify, k)));
            end
            read_done = 1'b1;
        end
        if (exp_n == 0) begin
            lat       = 0;
            ever_high = 1'b0;
            while (!layer_done && lat < 10) begin
                @(negedge aclk);
                start = 1'b0;
                lat++;
                if (send_header) ever_high = 1'b1;
            end
            check("empty_layer_done_latency", 32'(lat), 32'd2);
            check("empty_no_send_header", 32'(ever_high), 32'd0);
        end else begin
            @(negedge aclk);
            read_done = 1'b0;
            check("layer_done_pulse", 32'(layer_done), 32'd1);
            check("send_header_low_at_fin", 32'(send_header), 32'd0);
        end
        check("busy_low_at_fin", 32'(busy), 32'd0);
        @(negedge aclk);
        check("layer_done_one_cycle", 32'(layer_done), 32'd0);
    endtask

    typedef struct {
        logic [15:0] count;
        bit          notify;
        logic [2:0]  bs;
        logic [2:0]  be;
        logic [7:0]  lid;
        int          exp_pkts;
        logic [15:0] exp_last;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int          pkts;
        int          n;
        logic [15:0] last;
        logic [15:0] rcount;
        logic [2:0]  rbs;
        bit          rnotify;

        vecs[0] = '{16'd600, 1'b0, 3'd0, 3'd7, 8'h11, 3, 16'd88};
        vecs[1] = '{16'd256, 1'b0, 3'd2, 3'd5, 8'h22, 1, 16'd256};
        vecs[2] = '{16'd257, 1'b0, 3'd1, 3'd1, 8'h33, 2, 16'd1};
        vecs[3] = '{16'd1,   1'b0, 3'd7, 3'd7, 8'h44, 1, 16'd1};
        vecs[4] = '{16'd0,   1'b0, 3'd0, 3'd3, 8'h55, 0, 16'd0};
        vecs[5] = '{16'd100, 1'b1, 3'd4, 3'd6, 8'h66, 1, 16'd0};
        vecs[6] = '{16'd512, 1'b0, 3'd3, 3'd3, 8'h77, 2, 16'd256};

        areset         = 1'b1;
        start          = 1'b0;
        notify_mode    = 1'b0;
        layer_id       = '0;
        cfg_bram_start = '0;
        cfg_bram_end   = '0;
        cfg_addr_count = '0;
        read_done      = 1'b0;
        repeat (3) @(negedge aclk);
        check("rst_send_header", 32'(send_header), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_layer_done", 32'(layer_done), 32'd0);
        check("rst_error_timeout", 32'(error_timeout), 32'd0);
        check("rst_w0", 32'(header_word_0), 32'd0);
        check("rst_rd_addr_count", 32'(out_mgr_rd_addr_count), 32'd0);
        areset = 1'b0;
        @(negedge aclk);

        foreach (vecs[i]) begin
            run_layer(vecs[i].count, vecs[i].notify, vecs[i].bs, vecs[i].be, vecs[i].lid,
                      1'b0, pkts, last);
            check("table_packets", 32'(pkts), 32'(vecs[i].exp_pkts));
            check("table_last_chunk", 32'(last), 32'(vecs[i].exp_last));
        end

        // start pulsed while waiting for read_done is ignored
        run_layer(16'd700, 1'b0, 3'd1, 3'd6, 8'hA5, 1'b1, pkts, last);
        check("intrude_packets", 32'(pkts), 32'd3);

        // no read_done: watchdog fires after 100 cycles in WAIT
        cfg_addr_count = 16'd300;
        notify_mode    = 1'b0;
        cfg_bram_start = 3'd0;
        cfg_bram_end   = 3'd7;
        layer_id       = 8'h0E;
        start          = 1'b1;
        n = 0;
        while (!error_timeout && n < 200) begin
            @(negedge aclk);
            start = 1'b0;
            n++;
        end
        check("timeout_in_window", 32'(n >= 101 && n <= 105), 32'd1);
        check("timeout_send_header_low", 32'(send_header), 32'd0);
        check("timeout_layer_done", 32'(layer_done), 32'd1);
        repeat (3) @(negedge aclk);
        check("timeout_sticky", 32'(error_timeout), 32'd1);
        check("timeout_idle", 32'(busy), 32'd0);
        run_layer(16'd10, 1'b0, 3'd2, 3'd2, 8'h0F, 1'b0, pkts, last);
        check("timeout_cleared_by_start", 32'(error_timeout), 32'd0);

        // reset while a packet is outstanding
        cfg_addr_count = 16'd600;
        notify_mode    = 1'b0;
        start          = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            start = 1'b0;
        end
        check("pre_reset_send_header", 32'(send_header), 32'd1);
        areset = 1'b1;
        @(negedge aclk);
        check("midreset_send_header", 32'(send_header), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_w4", 32'(header_word_4), 32'd0);
        check("midreset_rd_addr_count", 32'(out_mgr_rd_addr_count), 32'd0);
        areset = 1'b0;
        @(negedge aclk);
        run_layer(16'd300, 1'b0, 3'd5, 3'd7, 8'hBE, 1'b0, pkts, last);
        check("post_reset_packets", 32'(pkts), 32'd2);

        // randomized layers against the model
        for (int r = 0; r < 12; r++) begin
            rcount  = 16'($urandom_range(0, 1100));
            rnotify = ($urandom_range(0, 5) == 0);
            rbs     = 3'($urandom_range(0, 7));
            run_layer(rcount, rnotify, rbs, 3'($urandom_range(int'(rbs), 7)),
                      8'($urandom_range(0, 255)), 1'b0, pkts, last);
            check("rand_packets", 32'(pkts), 32'(model_packets(int'(rcount), rnotify)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
